// File: rtl/axi4_mem_scheduler.sv
// AXI4 write/read burst scheduler sharing one single-port memory, one burst at a time.
// Define AXI4_MEM_SCHED_RR_EN for round-robin arbitration; default is write-priority.
module axi4_mem_scheduler #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned MEMORY_DEPTH = 1024
) (
   input  logic                            ACLK,
   input  logic                            ARESETn,
   input  logic [ADDR_WIDTH-1:0]           AWADDR,
   input  logic [7:0]                      AWLEN,
   input  logic                            AWVALID,
   output logic                            AWREADY,
   input  logic [DATA_WIDTH-1:0]           WDATA,
   input  logic                            WVALID,
   output logic                            WREADY,
   input  logic                            WLAST,
   output logic [1:0]                      BRESP,
   output logic                            BVALID,
   input  logic                            BREADY,
   input  logic [ADDR_WIDTH-1:0]           ARADDR,
   input  logic [7:0]                      ARLEN,
   input  logic                            ARVALID,
   output logic                            ARREADY,
   output logic [DATA_WIDTH-1:0]           RDATA,
   output logic [1:0]                      RRESP,
   output logic                            RVALID,
   input  logic                            RREADY,
   output logic                            RLAST,
   output logic                            mem_en,
   output logic                            mem_we,
   output logic [$clog2(MEMORY_DEPTH)-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_wdata,
   input  logic [DATA_WIDTH-1:0]           mem_rdata
);

   localparam int unsigned MAW   = $clog2(MEMORY_DEPTH);
   localparam int unsigned SHIFT = $clog2(DATA_WIDTH / 8);
   // One extra bit so a burst running past the top of memory never wraps.
   localparam int unsigned IDXW  = ADDR_WIDTH + 1;
   localparam logic [IDXW-1:0] DEPTH_W     = IDXW'(MEMORY_DEPTH);
   localparam logic [1:0]      RESP_OKAY   = 2'b00;
   localparam logic [1:0]      RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_DATA} state_t;

   state_t                  r_state;
   logic                    r_awready, r_arready, r_wready, r_bvalid, r_rvalid, r_rlast;
   logic [1:0]              r_bresp, r_rresp;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic [IDXW-1:0]         r_idx;
   logic [7:0]              r_beat, r_len;
   logic                    r_err;
`ifdef AXI4_MEM_SCHED_RR_EN
   logic                    r_last_wr;
`endif

   logic w_oor, w_last_beat, w_wr_fire, w_beat_err, w_mem_en, w_grant_rd, w_grant_wr;

   assign w_oor       = (r_idx >= DEPTH_W);
   assign w_last_beat = (r_beat == r_len);
   assign w_wr_fire   = (r_state == WR_DATA) && r_wready && WVALID;
   assign w_beat_err  = w_oor || (WLAST != w_last_beat);
   assign w_mem_en    = (w_wr_fire || (r_state == RD_ISSUE)) && !w_oor;

`ifdef AXI4_MEM_SCHED_RR_EN
   assign w_grant_rd  = ARVALID && (!AWVALID || r_last_wr);
`else
   assign w_grant_rd  = ARVALID && !AWVALID;
`endif
   assign w_grant_wr  = AWVALID && !w_grant_rd;

   assign mem_en    = w_mem_en;
   assign mem_we    = w_wr_fire && !w_oor;
   assign mem_addr  = w_mem_en ? r_idx[MAW-1:0] : '0;
   assign mem_wdata = (w_wr_fire && !w_oor) ? WDATA : '0;

   assign AWREADY = r_awready;
   assign ARREADY = r_arready;
   assign WREADY  = r_wready;
   assign BVALID  = r_bvalid;
   assign BRESP   = r_bresp;
   assign RVALID  = r_rvalid;
   assign RDATA   = r_rdata;
   assign RRESP   = r_rresp;
   assign RLAST   = r_rlast;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state   <= IDLE;
         r_awready <= 1'b0;
         r_arready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_rlast   <= 1'b0;
         r_idx     <= '0;
         r_beat    <= '0;
         r_len     <= '0;
         r_err     <= 1'b0;
`ifdef AXI4_MEM_SCHED_RR_EN
         r_last_wr <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               // READY is a one-cycle pulse; the master holds VALID, so it completes the handshake.
               if (r_awready) begin
                  r_awready <= 1'b0;
                  if (AWVALID) begin
                     r_idx    <= {1'b0, AWADDR} >> SHIFT;
                     r_len    <= AWLEN;
                     r_beat   <= '0;
                     r_err    <= 1'b0;
                     r_wready <= 1'b1;
                     r_state  <= WR_DATA;
                  end
               end else if (r_arready) begin
                  r_arready <= 1'b0;
                  if (ARVALID) begin
                     r_idx   <= {1'b0, ARADDR} >> SHIFT;
                     r_len   <= ARLEN;
                     r_beat  <= '0;
                     r_state <= RD_ISSUE;
                  end
               end else if (w_grant_wr) begin
                  r_awready <= 1'b1;
`ifdef AXI4_MEM_SCHED_RR_EN
                  r_last_wr <= 1'b1;
`endif
               end else if (w_grant_rd) begin
                  r_arready <= 1'b1;
`ifdef AXI4_MEM_SCHED_RR_EN
                  r_last_wr <= 1'b0;
`endif
               end
            end
            WR_DATA: begin
               if (w_wr_fire) begin
                  if (w_last_beat) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bresp  <= (r_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                     r_state  <= WR_RESP;
                  end else begin
                     r_err  <= r_err || w_beat_err;
                     r_idx  <= r_idx + IDXW'(1);
                     r_beat <= r_beat + 8'd1;
                  end
               end
            end
            WR_RESP: begin
               if (BREADY) begin
                  r_bvalid <= 1'b0;
                  r_bresp  <= RESP_OKAY;
                  r_state  <= IDLE;
               end
            end
            RD_ISSUE: r_state <= RD_DATA;
            RD_DATA: begin
               // First cycle here captures mem_rdata from the previous cycle's strobe.
               if (!r_rvalid) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= w_oor ? '0 : mem_rdata;
                  r_rresp  <= w_oor ? RESP_SLVERR : RESP_OKAY;
                  r_rlast  <= w_last_beat;
               end else if (RREADY) begin
                  r_rvalid <= 1'b0;
                  r_rdata  <= '0;
                  r_rresp  <= RESP_OKAY;
                  r_rlast  <= 1'b0;
                  if (w_last_beat) begin
                     r_state <= IDLE;
                  end else begin
                     r_idx   <= r_idx + IDXW'(1);
                     r_beat  <= r_beat + 8'd1;
                     r_state <= RD_ISSUE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_mem_scheduler.sv
// Scoreboard bench for axi4_mem_scheduler: directed bursts push expectations, a negedge
// monitor pops and compares on every B/R handshake, memory write and address grant.
module tb_axi4_mem_scheduler;

   logic        ACLK, ARESETn;
   logic [15:0] AWADDR, ARADDR;
   logic [7:0]  AWLEN, ARLEN;
   logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
   logic [31:0] WDATA, RDATA, mem_wdata, mem_rdata;
   logic [1:0]  BRESP, RRESP;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;

   axi4_mem_scheduler #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Synchronous single-port memory model, preloaded with 0xC0DE0000 | index.
   logic [31:0] mem [1024];
   always @(posedge ACLK) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
   typedef struct packed {logic [9:0] addr; logic [31:0] data;} mw_t;

   logic [1:0] q_b[$];
   rbeat_t     q_r[$];
   mw_t        q_mw[$];
   logic [7:0] q_g[$];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endfunction

   function automatic void flag(input string name, input string what);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %s", name, what);
   endfunction

   // Monitor: compare every observed DUT event against the head of its queue.
   logic        hold_pend = 1'b0;
   logic [31:0] hold_data = '0;
   always @(negedge ACLK) begin
      if (!ARESETn) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("r_hold_valid", 64'(RVALID), 64'(1));
            check("r_hold_data", 64'(RDATA), 64'(hold_data));
         end
         hold_pend = RVALID && !RREADY;
         hold_data = RDATA;
         if (BVALID || RVALID) check("b_r_exclusive", 64'(BVALID && RVALID), 64'(0));
         if (AWREADY || ARREADY) begin
            check("one_ready", 64'(AWREADY && ARREADY), 64'(0));
            if (q_g.size() == 0) flag("grant", "unexpected grant");
            else check("grant", 64'(AWREADY ? 8'("W") : 8'("R")), 64'(q_g.pop_front()));
         end
         if (BVALID && BREADY) begin
            if (q_b.size() == 0) flag("bresp", "unexpected B response");
            else check("bresp", 64'(BRESP), 64'(q_b.pop_front()));
         end
         if (RVALID && RREADY) begin
            if (q_r.size() == 0) flag("rbeat", "unexpected R beat");
            else check("rbeat{data,resp,last}", 64'({RDATA, RRESP, RLAST}), 64'(q_r.pop_front()));
         end
         if (mem_en && mem_we) begin
            if (q_mw.size() == 0) flag("memwr", "unexpected memory write");
            else check("memwr{addr,data}", 64'({mem_addr, mem_wdata}), 64'(q_mw.pop_front()));
         end
      end
   end

   function automatic logic sig(input int which);
      case (which)
         0:       return AWREADY;
         1:       return WREADY;
         2:       return BVALID;
         3:       return ARREADY;
         default: return RVALID;
      endcase
   endfunction

   // Wait (bounded) until the selected output is high at a negedge.
   task automatic wait_neg(input int which, input string name);
      for (int c = 0; c < 200; c++) begin
         @(negedge ACLK);
         if (sig(which)) return;
      end
      flag(name, "timeout");
   endtask

   task automatic do_write(input logic [15:0] addr, input int len, input int wlast_beat,
                           input logic [31:0] base, input int idx0, input logic [1:0] resp,
                           input bit push_g);
      if (push_g) q_g.push_back(8'("W"));
      q_b.push_back(resp);
      for (int b = 0; b <= len; b++)
         if (idx0 + b < 1024) q_mw.push_back({10'(idx0 + b), base + 32'(b)});
      AWADDR  = addr;
      AWLEN   = 8'(len);
      AWVALID = 1'b1;
      wait_neg(0, "aw_ready_wait");
      @(posedge ACLK); #1;
      AWVALID = 1'b0;
      for (int b = 0; b <= len; b++) begin
         WDATA  = base + 32'(b);
         WLAST  = (b == wlast_beat);
         WVALID = 1'b1;
         wait_neg(1, "w_ready_wait");
         @(posedge ACLK); #1;
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
      wait_neg(2, "b_valid_wait");
      @(posedge ACLK); #1;
   endtask

   // Caller pushes the expected beats; toggle stalls every other valid cycle (1,0,1,...).
   task automatic do_read(input logic [15:0] addr, input int len, input bit toggle, input bit push_g);
      int got = 0;
      int vc  = 0;
      int cyc = 0;
      if (push_g) q_g.push_back(8'("R"));
      ARADDR  = addr;
      ARLEN   = 8'(len);
      ARVALID = 1'b1;
      RREADY  = 1'b1;
      wait_neg(3, "ar_ready_wait");
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      while (got <= len && cyc < 400) begin
         @(negedge ACLK);
         if (RVALID && RREADY) got++;
         @(posedge ACLK); #1;
         cyc++;
         if (RVALID) begin
            RREADY = toggle ? (vc % 2 == 0) : 1'b1;
            vc++;
         end
      end
      if (got <= len) flag("read_beats", "timeout");
      RREADY = 1'b1;
   endtask

   initial begin
      ARESETn = 1'b0;
      AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
      WDATA = '0; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
      ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem_rdata = '0;
      repeat (3) @(negedge ACLK);
      check("reset_ctrl", 64'({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, mem_en, mem_we,
                               BRESP, RRESP, mem_addr}), 64'(0));
      check("reset_data", 64'({RDATA, mem_wdata}), 64'(0));

      // Requests already pending when reset lifts must not be acknowledged that cycle.
      AWVALID = 1'b1;
      ARVALID = 1'b1;
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      @(negedge ACLK);
      check("first_cycle_hs", 64'({AWREADY, WREADY, BVALID, ARREADY, RVALID}), 64'(0));
      ARVALID = 1'b0;

      // Burst of 4 to 0x0010: words 4..7.
      do_write(16'h0010, 3, 3, 32'hA000_0004, 4, 2'b00, 1'b1);

      q_r.push_back({32'hA000_0004, 2'b00, 1'b0});
      q_r.push_back({32'hA000_0005, 2'b00, 1'b0});
      q_r.push_back({32'hA000_0006, 2'b00, 1'b0});
      q_r.push_back({32'hA000_0007, 2'b00, 1'b1});
      do_read(16'h0010, 3, 1'b1, 1'b1);

      // Runs off the top: index 1023 written, 1024 suppressed.
      do_write(16'h0FFC, 1, 1, 32'hB000_0000, 1023, 2'b10, 1'b1);
      q_r.push_back({32'hB000_0000, 2'b00, 1'b0});
      q_r.push_back({32'h0000_0000, 2'b10, 1'b1});
      do_read(16'h0FFC, 1, 1'b0, 1'b1);

      // WLAST on beat 2 of 4: all beats still written.
      do_write(16'h0040, 3, 1, 32'hC000_0010, 16, 2'b10, 1'b1);
      q_r.push_back({32'hC000_0010, 2'b00, 1'b1});
      do_read(16'h0040, 0, 1'b0, 1'b1);

      // Both channels requesting for three grants.
`ifdef AXI4_MEM_SCHED_RR_EN
      q_g.push_back(8'("W")); q_g.push_back(8'("R")); q_g.push_back(8'("W"));
      q_r.push_back({32'hC0DE_0040, 2'b00, 1'b1});
      fork
         begin
            do_write(16'h0200, 0, 0, 32'hD000_0080, 128, 2'b00, 1'b0);
            do_write(16'h0204, 0, 0, 32'hD000_0081, 129, 2'b00, 1'b0);
         end
         do_read(16'h0100, 0, 1'b0, 1'b0);
      join
`else
      q_g.push_back(8'("W")); q_g.push_back(8'("W")); q_g.push_back(8'("W"));
      q_g.push_back(8'("R"));
      q_r.push_back({32'hC0DE_0040, 2'b00, 1'b1});
      fork
         begin
            do_write(16'h0200, 0, 0, 32'hD000_0080, 128, 2'b00, 1'b0);
            do_write(16'h0204, 0, 0, 32'hD000_0081, 129, 2'b00, 1'b0);
            do_write(16'h0208, 0, 0, 32'hD000_0082, 130, 2'b00, 1'b0);
         end
         do_read(16'h0100, 0, 1'b0, 1'b0);
      join
`endif

      // Reset while read beat 2 is being presented.
      q_g.push_back(8'("R"));
      q_r.push_back({32'hA000_0004, 2'b00, 1'b0});
      ARADDR  = 16'h0010;
      ARLEN   = 8'd3;
      ARVALID = 1'b1;
      RREADY  = 1'b1;
      wait_neg(3, "ar_ready_wait");
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      wait_neg(4, "r_beat1_wait");
      @(posedge ACLK); #1;
      RREADY = 1'b0;
      wait_neg(4, "r_beat2_wait");
      #1;
      ARESETn = 1'b0;
      #1;
      check("midburst_rst_ctrl", 64'({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, mem_en,
                                      mem_we, BRESP, RRESP, mem_addr}), 64'(0));
      check("midburst_rst_data", 64'({RDATA, mem_wdata}), 64'(0));
      RREADY = 1'b1;
      AWVALID = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      @(negedge ACLK);
      check("post_rst_first_cycle_hs", 64'({AWREADY, WREADY, BVALID, ARREADY, RVALID}), 64'(0));
      do_write(16'h0080, 1, 1, 32'hE000_0020, 32, 2'b00, 1'b1);
      q_r.push_back({32'hE000_0020, 2'b00, 1'b0});
      q_r.push_back({32'hE000_0021, 2'b00, 1'b1});
      do_read(16'h0080, 1, 1'b0, 1'b1);

      repeat (5) @(negedge ACLK);
      check("q_b_drained", 64'(q_b.size()), 64'(0));
      check("q_r_drained", 64'(q_r.size()), 64'(0));
      check("q_mw_drained", 64'(q_mw.size()), 64'(0));
      check("q_g_drained", 64'(q_g.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi4_mem_scheduler.md
AXI4_MEM_SCHEDULER -- requirements
Module: axi4_mem_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: AXI and memory data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: AXI byte-address width.
REQ-003 SHALL have parameter MEMORY_DEPTH, default 1024: memory depth in DATA_WIDTH words.
REQ-004 SHALL have ACLK  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have ARESETn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have AWADDR  in  ADDR_WIDTH  write burst start byte address.
REQ-007 SHALL have AWLEN  in  8  write beats minus 1.
REQ-008 SHALL have AWVALID/AWREADY  in/out  1/1  write-address handshake.
REQ-009 SHALL have WDATA  in  DATA_WIDTH  write beat data.
REQ-010 SHALL have WVALID/WREADY  in/out  1/1  write-data handshake.
REQ-011 SHALL have WLAST  in  1  master's final-beat marker.
REQ-012 SHALL have BRESP  out  2  write response, OKAY=00, SLVERR=10.
REQ-013 SHALL have BVALID/BREADY  out/in  1/1  write-response handshake.
REQ-014 SHALL have ARADDR  in  ADDR_WIDTH  read burst start byte address.
REQ-015 SHALL have ARLEN  in  8  read beats minus 1.
REQ-016 SHALL have ARVALID/ARREADY  in/out  1/1  read-address handshake.
REQ-017 SHALL have RDATA  out  DATA_WIDTH  read beat data.
REQ-018 SHALL have RRESP  out  2  read beat response, OKAY/SLVERR.
REQ-019 SHALL have RVALID/RREADY  out/in  1/1  read-data handshake.
REQ-020 SHALL have RLAST  out  1  asserted with final read beat.
REQ-021 SHALL have mem_en  out  1  single-port memory access strobe.
REQ-022 SHALL have mem_we  out  1  write enable, valid with mem_en.
REQ-023 SHALL have mem_addr  out  $clog2(MEMORY_DEPTH)  word address.
REQ-024 SHALL have mem_wdata  out  DATA_WIDTH  memory write data.
REQ-025 SHALL have mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after read strobe.

Function
REQ-026 SHALL share one single-port memory between AXI write and read bursts, one burst at a time; INCR, full-width beats only (size fixed).
REQ-027 SHALL use FSM states IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_DATA; IDLE->WR_DATA or RD_ISSUE on grant; WR_DATA->WR_RESP after beat AxLEN+1; WR_RESP->IDLE on B handshake; RD_ISSUE->RD_DATA next cycle; RD_DATA->RD_ISSUE on R handshake of non-last beat, ->IDLE on last.
REQ-028 SHALL in IDLE grant one requester: AWREADY or ARREADY high for exactly one cycle, never both; address and length latched on that handshake; arbitration per REQ-036.
REQ-029 SHALL compute word index = AxADDR >> $clog2(DATA_WIDTH/8), incremented by 1 per beat; an index >= MEMORY_DEPTH marks that beat out-of-range, no wrap-around.
REQ-030 SHALL hold WREADY high only in WR_DATA; each W handshake drives mem_en=1, mem_we=mem_wdata-valid same cycle, except out-of-range beats, which are suppressed (mem_en=0).
REQ-031 SHALL end a write burst after exactly AWLEN+1 W handshakes; BRESP=SLVERR if any beat was out-of-range, WLAST was high before the final beat, or WLAST was low on the final beat; else OKAY.
REQ-032 SHALL in RD_ISSUE drive mem_en=1, mem_we=0 for one cycle (mem_en=0 if out-of-range); in RD_DATA hold RVALID, RDATA, RRESP, RLAST stable until RREADY; RRESP=SLVERR and RDATA=0 for out-of-range beats.
REQ-033 SHALL hold BVALID/BRESP stable until BREADY; BVALID, RVALID never high together.

Reset
REQ-034 SHALL on ARESETn low, immediately and regardless of state: FSM=IDLE; AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, mem_en, mem_we=0; BRESP, RRESP, RDATA, mem_addr, mem_wdata=0; beat counters and error flags cleared; arbitration pointer=write-first. An interrupted burst is abandoned, no response issued.
REQ-035 SHALL drive no handshake output high in the first cycle after ARESETn deasserts.

Configuration
REQ-036 SHALL, with macro AXI4_MEM_SCHED_RR_EN defined, arbitrate round-robin: on simultaneous AWVALID and ARVALID, grant the channel not granted last (write first after reset); without it, write always wins; a lone request is always granted.

Verification
REQ-037 SHALL cover: AWADDR=0x0010, AWLEN=3, WLAST on beat 4 -> mem writes to indices 4..7, one BRESP=OKAY.
REQ-038 SHALL cover: ARADDR=0x0010, ARLEN=3, RREADY toggling 1,0,1 -> RDATA equals words 4..7, held while RREADY=0, RLAST only on beat 4.
REQ-039 SHALL cover: AWVALID and ARVALID both high for 3 bursts -> grants W,R,W with RR_EN; W,W,W without.
REQ-040 SHALL cover: AWADDR=0x0FFC, AWLEN=1 (MEMORY_DEPTH=1024) -> index 1023 written, index 1024 suppressed, BRESP=SLVERR.
REQ-041 SHALL cover: WLAST on beat 2 of AWLEN=3 -> all 4 beats written, BRESP=SLVERR.
REQ-042 SHALL cover: ARESETn low during read beat 2 -> all outputs zero same cycle, IDLE, next AW granted normally.
